plic_irq_arbiter: RTL

//  Platform-level interrupt controller between the SoC peripheral IRQ lines (uart, spi_flash, spi2, gpio, i2c, ptc) and the rv32i core.
//  - Gateways each source into a pending bit and arbitrates by priority/threshold.
//  - Drives the core's single machine external interrupt.
//  - Exposes claim/complete plus configuration through a single-cycle register port.

---
 rtl/plic_irq_arbiter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/plic_irq_arbiter.sv
// plic_irq_arbiter
// Sits between the peripheral IRQ lines and the core's machine external
// interrupt. Each source has a gateway (IDLE/PEND/CLAIMED). Pending sources
// are arbitrated by priority against a threshold. Claim/complete and all
// configuration go through a single-cycle register port.
// Optional feature: define PLIC_EDGE_EN to add per-source edge triggering
// (TRIGGER register at 0x50 with a one-deep missed-edge flag).
//
// Gateway FSM (one instance per source)
//   state      | meaning
//   GW_IDLE    | no request outstanding, watching the source line
//   GW_PEND    | request latched, taking part in arbitration
//   GW_CLAIMED | handed to the core, waiting for COMPLETE; line ignored
module plic_irq_arbiter #(
  parameter int NUM_SRC = 6,
  parameter int PRIO_W  = 3,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               reg_sel_i,
  input  logic               reg_we_i,
  input  logic [ADDR_W-1:0]  reg_addr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic [31:0]        reg_rdata_o,
  output logic               reg_ack_o,
  output logic               irq_o
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  localparam logic [ADDR_W-1:0] A_PENDING = ADDR_W'(32'h40);
  localparam logic [ADDR_W-1:0] A_ENABLE  = ADDR_W'(32'h44);
  localparam logic [ADDR_W-1:0] A_THRESH  = ADDR_W'(32'h48);
  localparam logic [ADDR_W-1:0] A_CLAIM   = ADDR_W'(32'h4C);
`ifdef PLIC_EDGE_EN
  localparam logic [ADDR_W-1:0] A_TRIGGER = ADDR_W'(32'h50);
`endif

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PEND    = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  gw_state_e         gw_q   [1:NUM_SRC];
  gw_state_e         gw_d   [1:NUM_SRC];
  logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
  logic [NUM_SRC:1]  en_q;
  logic [NUM_SRC:1]  pend;
  logic [NUM_SRC:1]  fire;
  logic [PRIO_W-1:0] thresh_q;
  logic [PRIO_W-1:0] best_prio;
  logic [ID_W-1:0]   winner_q;
  logic [ID_W-1:0]   winner_d;
  logic              ack_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rdata_d;

  logic access;
  logic wr_en;
  logic rd_en;
  logic claim_en;
  logic complete_en;

  // An access is performed on the edge that raises ack; a held sel therefore
  // completes every second cycle.
  assign access      = reg_sel_i && !ack_q;
  assign wr_en       = access && reg_we_i;
  assign rd_en       = access && !reg_we_i;
  assign claim_en    = rd_en && (reg_addr_i == A_CLAIM);
  assign complete_en = wr_en && (reg_addr_i == A_CLAIM);

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;
  assign irq_o       = (winner_q != '0);

`ifdef PLIC_EDGE_EN
  logic [NUM_SRC:1] trig_q;
  logic [NUM_SRC:1] src_q;
  logic [NUM_SRC:1] rise;
  logic [NUM_SRC:1] missed_q;
  logic [NUM_SRC:1] missed_d;

  // Previous sample of the source lines for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q <= '0;
    end else begin
      src_q <= irq_src_i;
    end
  end

  assign rise = irq_src_i & ~src_q;
  assign fire = (trig_q & rise) | (~trig_q & irq_src_i);

  // One-deep record of an edge that arrived while the source was claimed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      missed_q <= '0;
    end else begin
      missed_q <= missed_d;
    end
  end
`else
  assign fire = irq_src_i;
`endif

  // Pending view of the gateway states.
  always_comb begin
    pend = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      pend[k] = (gw_q[k] == GW_PEND);
    end
  end

  // Gateway next-state: trigger, claim by the registered winner, complete.
  always_comb begin
`ifdef PLIC_EDGE_EN
    missed_d = missed_q;
`endif
    for (int k = 1; k <= NUM_SRC; k++) begin
      gw_d[k] = gw_q[k];
      case (gw_q[k])
        GW_IDLE: begin
          if (fire[k]) gw_d[k] = GW_PEND;
        end
        GW_PEND: begin
          if (claim_en && (winner_q == ID_W'(k))) gw_d[k] = GW_CLAIMED;
        end
        GW_CLAIMED: begin
          if (complete_en && (reg_wdata_i == 32'(k))) begin
`ifdef PLIC_EDGE_EN
            gw_d[k]     = (missed_q[k] || (trig_q[k] && rise[k])) ? GW_PEND : GW_IDLE;
            missed_d[k] = 1'b0;
`else
            gw_d[k] = GW_IDLE;
`endif
          end
`ifdef PLIC_EDGE_EN
          else if (trig_q[k] && rise[k]) begin
            missed_d[k] = 1'b1;
          end
`endif
        end
        default: gw_d[k] = GW_IDLE;
      endcase
    end
  end

  // Gateway state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        gw_q[k] <= GW_IDLE;
      end
    end else begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        gw_q[k] <= gw_d[k];
      end
    end
  end

  // Highest eligible priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    winner_d  = '0;
    best_prio = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (pend[k] && en_q[k] && (prio_q[k] > thresh_q) && (prio_q[k] > best_prio)) begin
        winner_d  = ID_W'(k);
        best_prio = prio_q[k];
      end
    end
  end

  // Registered winner drives irq_o and the claim value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      winner_q <= '0;
    end else begin
      winner_q <= winner_d;
    end
  end

  // Configuration register writes, applied at the ack edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        prio_q[k] <= '0;
      end
      en_q     <= '0;
      thresh_q <= '0;
`ifdef PLIC_EDGE_EN
      trig_q   <= '0;
`endif
    end else if (wr_en) begin
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (reg_addr_i == ADDR_W'(4 * k)) prio_q[k] <= reg_wdata_i[PRIO_W-1:0];
      end
      if (reg_addr_i == A_ENABLE) en_q     <= reg_wdata_i[NUM_SRC:1];
      if (reg_addr_i == A_THRESH) thresh_q <= reg_wdata_i[PRIO_W-1:0];
`ifdef PLIC_EDGE_EN
      if (reg_addr_i == A_TRIGGER) trig_q  <= reg_wdata_i[NUM_SRC:1];
`endif
    end
  end

  // Read decode; unmapped addresses return 0.
  always_comb begin
    rdata_d = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (reg_addr_i == ADDR_W'(4 * k)) rdata_d = 32'(prio_q[k]);
    end
    case (reg_addr_i)
      A_PENDING: rdata_d = 32'({pend, 1'b0});
      A_ENABLE:  rdata_d = 32'({en_q, 1'b0});
      A_THRESH:  rdata_d = 32'(thresh_q);
      A_CLAIM:   rdata_d = 32'(winner_q);
`ifdef PLIC_EDGE_EN
      A_TRIGGER: rdata_d = 32'({trig_q, 1'b0});
`endif
      default: ;
    endcase
  end

  // Ack pulse and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= access;
      rdata_q <= rd_en ? rdata_d : '0;
    end
  end

endmodule
